vector_bypass_history: RTL
==========================

# vector_bypass_history

Parametrised vector operand bypass block with an internal writeback history. It captures each vector writeback into a DEPTH-entry shift history and resolves NUM_PORTS operand reads per lane against it, youngest first, with the register file value as fallback. It sits between the vector register file read and the execute stage and replaces hand-wired per-stage bypass taps with a single tracked history. Results are registered, and the block supports flush and read stall.

## Interface
- NUM_LANES, 16: word lanes per vector.
- LANE_WIDTH, 32: bits per lane.
- REG_BITS, 7: register index width.
- DEPTH, 4: writeback history entries (1..8).
- NUM_PORTS, 2: independent read ports.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_en  in  1  a vector writeback is issued this cycle.
- wb_reg  in  REG_BITS  writeback destination register.
- wb_mask  in  NUM_LANES  per-lane write enable.
- wb_value  in  NUM_LANES*LANE_WIDTH  writeback data; lane i is bits [i*LANE_WIDTH +: LANE_WIDTH].
- flush  in  1  discard all history and the same-cycle writeback.
- rd_en  in  1  capture new read results; when low, outputs hold.
- rd_reg  in  NUM_PORTS*REG_BITS  per-port source register.
- rf_data  in  NUM_PORTS*NUM_LANES*LANE_WIDTH  per-port register file value.
- value_o  out  NUM_PORTS*NUM_LANES*LANE_WIDTH  registered bypassed operand.
- hit_mask_o  out  NUM_PORTS*NUM_LANES  registered mask of lanes supplied from bypass rather than rf_data.

## Operation
- Each history entry holds valid, reg, mask and value. Entry 0 is the youngest.
- Every cycle, with no flush or reset, the history shifts by one:
  - Entry k+1 takes entry k.
  - Entry 0 takes {wb_en, wb_reg, wb_mask, wb_value}.
  - Entry DEPTH-1 falls off. Its write is committed to the register file by then, which is the DEPTH contract with the writeback pipeline.
- Per-port, per-lane resolution (combinational, then registered):
  - Priority 1: the same-cycle writeback, if wb_en, wb_reg==rd_reg and wb_mask[lane].
  - Priority 2: history entries 0..DEPTH-1 in order, using the first with valid, matching reg and mask[lane].
  - Otherwise the lane takes rf_data.
- A masked-off lane in a younger write falls through to older entries. Lanes are resolved independently.
- Register index 0 has no special treatment; all indices are bypassable.
- Ports are fully independent. Two ports reading the same register get identical results.
- flush:
  - Clears all valid bits at the edge and drops the same-cycle writeback from history.
  - The same-cycle read still sees the pre-flush history and the writeback if rd_en is high. Flush affects subsequent cycles only.
- reset: clears all valid bits, value_o, hit_mask_o and the hit counter. It overrides flush and wb_en.

## Timing
- Read latency is 1 cycle. rd_reg and rf_data sampled at edge N produce value_o and hit_mask_o valid after edge N.
- A writeback is bypassable in the same cycle it is issued, and in each of the following DEPTH cycles (DEPTH+1 cycles total).
- rd_en low: value_o and hit_mask_o hold their last values. The history keeps shifting regardless of rd_en.
- Reset values: value_o all 0, hit_mask_o all 0, all history entries invalid.
- A reset asserted mid-stream takes effect at the next edge. The first read after reset deasserts sees only rf_data and any same-cycle writeback.

## Configuration
- VECTOR_BYPASS_HIT_COUNT_EN defined:
  - Adds output hit_count_o, 32 bits, reset 0.
  - On each edge with rd_en high, it adds the number of ports whose hit_mask result has any lane set.
  - It saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then rd_en with rd_reg=5 and rf_data lanes=0x11111111 -> next cycle value_o lanes all 0x11111111, hit_mask_o=0.
- wb_en with reg 5, mask 0x00FF, value lanes 0xAAAAAAAA, same-cycle read of reg 5 -> lanes 0-7 are 0xAAAAAAAA, lanes 8-15 are rf_data, hit_mask 0x00FF.
- Write reg 3 with mask 0xFFFF and value A, then next cycle write reg 3 with mask 0x000F and value B, then read reg 3 -> lanes 0-3 are B, lanes 4-15 are A, hit_mask 0xFFFF.
- Write reg 9 with mask 0xFFFF, then read reg 9 at cycles +1..+DEPTH -> bypassed. Read at +DEPTH+1 -> rf_data with hit_mask 0.
- Write reg 2, then assert flush on the next cycle together with a read of reg 2 -> that read is bypassed. A read of reg 2 in the following cycle returns rf_data.
- With the counter enabled, run 10 cycles of rd_en with port 0 hitting and port 1 missing -> hit_count_o=10. Preload the counter at 0xFFFFFFFF -> it stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/vector_bypass_history_if.sv
// vector_bypass_history_if: writeback, read request and bypassed-result bundle for vector_bypass_history.
//   master drives: wb_en, wb_reg, wb_mask, wb_value, flush, rd_en, rd_reg, rf_data
//   slave drives : value_o, hit_mask_o (and hit_count_o when VECTOR_BYPASS_HIT_COUNT_EN is defined)
interface vector_bypass_history_if #(
    parameter int NUM_LANES  = 16,
    parameter int LANE_WIDTH = 32,
    parameter int REG_BITS   = 7,
    parameter int NUM_PORTS  = 2
);
    logic                                        wb_en;
    logic [REG_BITS-1:0]                         wb_reg;
    logic [NUM_LANES-1:0]                        wb_mask;
    logic [NUM_LANES*LANE_WIDTH-1:0]             wb_value;
    logic                                        flush;
    logic                                        rd_en;
    logic [NUM_PORTS*REG_BITS-1:0]               rd_reg;
    logic [NUM_PORTS*NUM_LANES*LANE_WIDTH-1:0]   rf_data;
    logic [NUM_PORTS*NUM_LANES*LANE_WIDTH-1:0]   value_o;
    logic [NUM_PORTS*NUM_LANES-1:0]              hit_mask_o;
`ifdef VECTOR_BYPASS_HIT_COUNT_EN
    logic [31:0]                                 hit_count_o;
    modport master (output wb_en, wb_reg, wb_mask, wb_value, flush, rd_en, rd_reg, rf_data,
                    input value_o, hit_mask_o, hit_count_o);
    modport slave  (input wb_en, wb_reg, wb_mask, wb_value, flush, rd_en, rd_reg, rf_data,
                    output value_o, hit_mask_o, hit_count_o);
`else
    modport master (output wb_en, wb_reg, wb_mask, wb_value, flush, rd_en, rd_reg, rf_data,
                    input value_o, hit_mask_o);
    modport slave  (input wb_en, wb_reg, wb_mask, wb_value, flush, rd_en, rd_reg, rf_data,
                    output value_o, hit_mask_o);
`endif
endinterface

// File: rtl/vector_bypass_history.sv
// vector_bypass_history: per-lane vector operand bypass from a DEPTH-entry writeback history.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset (clears history valids, outputs, hit counter)
//   bus   : vector_bypass_history_if.slave carrying writeback, flush, read request and registered results
// Optional feature: define VECTOR_BYPASS_HIT_COUNT_EN to add the saturating hit_count_o counter.
module vector_bypass_history #(
    parameter int NUM_LANES  = 16,
    parameter int LANE_WIDTH = 32,
    parameter int REG_BITS   = 7,
    parameter int DEPTH      = 4,
    parameter int NUM_PORTS  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    vector_bypass_history_if.slave   bus
);
    localparam int VW = NUM_LANES * LANE_WIDTH;

    logic [DEPTH-1:0]                r_valid;
    logic [REG_BITS-1:0]             r_reg   [DEPTH];
    logic [NUM_LANES-1:0]            r_mask  [DEPTH];
    logic [VW-1:0]                   r_value [DEPTH];
    logic [NUM_PORTS*VW-1:0]         r_out;
    logic [NUM_PORTS*VW-1:0]         w_out;
    logic [NUM_PORTS*NUM_LANES-1:0]  r_hit;
    logic [NUM_PORTS*NUM_LANES-1:0]  w_hit;

    // Walk oldest to youngest so younger matches overwrite older ones; the
    // same-cycle writeback is applied last and therefore wins.
    always_comb begin
        w_out = bus.rf_data;
        w_hit = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (r_valid[k] && r_reg[k] == bus.rd_reg[p*REG_BITS +: REG_BITS] && r_mask[k][l]) begin
                        w_out[(p*NUM_LANES+l)*LANE_WIDTH +: LANE_WIDTH] = r_value[k][l*LANE_WIDTH +: LANE_WIDTH];
                        w_hit[p*NUM_LANES+l] = 1'b1;
                    end
                end
                if (bus.wb_en && bus.wb_reg == bus.rd_reg[p*REG_BITS +: REG_BITS] && bus.wb_mask[l]) begin
                    w_out[(p*NUM_LANES+l)*LANE_WIDTH +: LANE_WIDTH] = bus.wb_value[l*LANE_WIDTH +: LANE_WIDTH];
                    w_hit[p*NUM_LANES+l] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_out   <= '0;
            r_hit   <= '0;
        end else begin
            r_valid[0] <= bus.wb_en && !bus.flush;
            for (int k = 1; k < DEPTH; k++)
                r_valid[k] <= r_valid[k-1] && !bus.flush;
            if (bus.rd_en) begin
                r_out <= w_out;
                r_hit <= w_hit;
            end
        end
        // Payload shifts unconditionally; only the valid bits carry meaning.
        r_reg[0]   <= bus.wb_reg;
        r_mask[0]  <= bus.wb_mask;
        r_value[0] <= bus.wb_value;
        for (int k = 1; k < DEPTH; k++) begin
            r_reg[k]   <= r_reg[k-1];
            r_mask[k]  <= r_mask[k-1];
            r_value[k] <= r_value[k-1];
        end
    end

    assign bus.value_o    = r_out;
    assign bus.hit_mask_o = r_hit;

`ifdef VECTOR_BYPASS_HIT_COUNT_EN
    logic [31:0] r_count;
    logic [31:0] w_nports;
    logic [32:0] w_sum;

    always_comb begin
        w_nports = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (|w_hit[p*NUM_LANES +: NUM_LANES]) w_nports = w_nports + 32'd1;
        w_sum = {1'b0, r_count} + {1'b0, w_nports};
    end

    always_ff @(posedge clk) begin
        if (reset) r_count <= '0;
        else if (bus.rd_en) r_count <= w_sum[32] ? '1 : w_sum[31:0];
    end

    assign bus.hit_count_o = r_count;
`endif
endmodule
